mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single-port word memory between the instruction-fetch path and the load/store path. It sits between the CPU front end and data path on one side and the memory on the other. It grants at most one access per cycle using round-robin priority, range- and alignment-checks each access, and returns a registered response one cycle after the grant. It also keeps a saturating stall counter for performance visibility.

## Interface
Parameters:
- DEPTH, 16, memory depth in 32-bit words; legal word index is 0..DEPTH-1
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch response valid, one-cycle pulse
- if_rdata  out  32  fetch read data
- if_err  out  1  fetch error, qualified by if_rvalid
- ls_req  in  1  load/store request; held high until ls_gnt
- ls_we  in  1  1 = write, 0 = read
- ls_addr  in  32  load/store byte address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store granted this cycle
- ls_rvalid  out  1  load/store response valid, one-cycle pulse
- ls_rdata  out  32  load read data; 0 for stores
- ls_err  out  1  load/store error, qualified by ls_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  byte address to memory; memory indexes by addr>>2
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data for mem_addr
- stall_cnt  out  CNT_W  saturating count of request-cycles left ungranted

## Operation
- Priority pointer `last` (1 bit; 0 = fetch, 1 = load/store) records the most recent grant.
- Grant rules (combinational, same cycle as request):
  - Exactly one requester high: grant it.
  - Both high: grant the requester not equal to `last`.
  - Neither high: no grant, and `last` is unchanged.
- On any grant, `last` updates to the granted requester at the clock edge.
- With both requesters held high continuously, grants alternate every cycle, so the maximum wait is 1 cycle.
- Legality check on the granted address: legal iff addr[1:0]==0 and addr[31:2] < DEPTH.
  - Legal access: mem_en=1, mem_addr=addr, mem_we=ls_we for load/store and 0 for fetch, mem_wdata=ls_wdata.
  - Illegal access: mem_en=0 and mem_we=0. The access is still granted, `last` still updates, and the response carries err=1.
- When mem_en=0, mem_addr and mem_wdata are driven to 0.
- Response register, captured at the grant-cycle edge:
  - Target requester's rvalid = 1 for exactly one cycle.
  - rdata = mem_rdata for a legal read; 0 for a write or an error.
  - err as determined by the legality check.
  - The other requester's rvalid = 0.
- rdata and err hold their last values while rvalid=0; consumers qualify them with rvalid.
- stall_cnt increments by 1 for each requester that has req=1 and gnt=0 in a cycle. It increases by at most 1 per cycle, because only one requester can be waiting. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Reset (rst_n low, asynchronous):
  - All registered outputs clear: if_rvalid, ls_rvalid, if_err, ls_err, if_rdata, ls_rdata = 0; stall_cnt = 0; `last` = 1, so fetch wins the first conflict.
  - Grants and mem_en are forced to 0 while rst_n is low.
- Grant latency is 0 cycles after req; response latency is 1 cycle after gnt.
- Back-to-back operation is supported: a new grant may occur in the same cycle as the previous response (full throughput, one access per cycle).
- A requester must keep req, addr, we and wdata stable until gnt. After gnt it may drop req or present a new request the next cycle.
- Reset asserted in the cycle after a grant drops the pending response; no rvalid is produced for it.
- Reset release: the first grant can occur in the first cycle with rst_n high.

## Test plan
- Reset: with rst_n=0, drive both req=1 -> if_gnt=ls_gnt=0, mem_en=0, all rvalid=0, stall_cnt=0. After release, a conflict grants fetch first.
- Single fetch: if_addr=0x8, memory word 2 = 0xDEADBEEF -> if_gnt=1 in the same cycle, mem_addr=0x8, then if_rvalid=1 with if_rdata=0xDEADBEEF the next cycle, if_err=0.
- Conflict round-robin: both req held high for 4 cycles -> grant order IF, LS, IF, LS; stall_cnt=4; each response arrives 1 cycle after its grant.
- Store then load: ls_we=1, ls_addr=0x3C, ls_wdata=0x12345678 -> mem_we=1 in the grant cycle and ls_rvalid=1 with ls_rdata=0; a following read of 0x3C returns 0x12345678.
- Errors: ls_addr=0x41 (misaligned) and if_addr=0x40 (word 16 ≥ DEPTH) -> mem_en=0 in each grant cycle, err=1 with rdata=0 in each response, and `last` still advances.
- Saturation and mid-operation reset: with CNT_W=2, stall for 5 cycles -> stall_cnt holds at 3. Asserting rst_n low the cycle after a grant -> no rvalid and stall_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port word memory
//               between the instruction-fetch path (if_*) and the load/store
//               path (ls_*). It grants at most one access per cycle, with
//               zero-cycle grant latency. Each granted address is checked for
//               word alignment and for range, and a registered response is
//               returned one cycle after the grant. A saturating counter
//               accumulates request-cycles that were left ungranted.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               if_req/if_addr        fetch request in
//               if_gnt/if_rvalid/if_rdata/if_err  fetch grant and response
//               ls_req/ls_we/ls_addr/ls_wdata     load/store request in
//               ls_gnt/ls_rvalid/ls_rdata/ls_err  load/store grant, response
//               mem_en/mem_we/mem_addr/mem_wdata  memory request out
//               mem_rdata             combinational memory read data in
//               stall_cnt             saturating ungranted-request counter
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    output logic             if_err,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [31:0]      ls_addr,
    input  logic [31:0]      ls_wdata,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [31:0]      ls_rdata,
    output logic             ls_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [29:0] c_depth_words = 30'(DEPTH);

    // r_last: most recent grant, 0 = fetch, 1 = load/store.
    logic              r_last;
    logic              w_if_gnt;
    logic              w_ls_gnt;
    logic              w_gnt;
    logic [31:0]       w_addr;
    logic              w_legal;
    logic              w_stall;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Round robin: on a conflict the requester that did not win last time
    // wins now. Grants are gated by rst_n so nothing is issued in reset.
    always_comb begin
        w_if_gnt = rst_n & if_req & (~ls_req | r_last);
        w_ls_gnt = rst_n & ls_req & (~if_req | ~r_last);
        w_gnt    = w_if_gnt | w_ls_gnt;
    end

    // Address of whichever requester is granted (fetch when none).
    assign w_addr  = w_ls_gnt ? ls_addr : if_addr;
    assign w_legal = (w_addr[1:0] == 2'b00) && (w_addr[31:2] < c_depth_words);

    // Illegal accesses are still granted but never reach the memory.
    always_comb begin
        mem_en    = w_gnt & w_legal;
        mem_we    = mem_en & w_ls_gnt & ls_we;
        mem_addr  = mem_en ? w_addr   : 32'd0;
        mem_wdata = mem_en ? ls_wdata : 32'd0;
    end

    assign if_gnt = w_if_gnt;
    assign ls_gnt = w_ls_gnt;

    // Only one requester can be waiting in any cycle, so +1 is the maximum.
    assign w_stall = (if_req & ~w_if_gnt) | (ls_req & ~w_ls_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_gnt) begin
            r_last <= w_ls_gnt;
        end
    end

    // Response register. rdata/err only update on a grant so they hold
    // their previous value while rvalid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= 32'd0;
            ls_err    <= 1'b0;
        end else begin
            if_rvalid <= w_if_gnt;
            ls_rvalid <= w_ls_gnt;
            if (w_if_gnt) begin
                if_rdata <= w_legal ? mem_rdata : 32'd0;
                if_err   <= ~w_legal;
            end
            if (w_ls_gnt) begin
                ls_rdata <= (w_legal && !ls_we) ? mem_rdata : 32'd0;
                ls_err   <= ~w_legal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
